ex_stage: RTL and testbench

- Execute stage of the toy MIPS pipeline.
- Consumes the decoded operation from instruction decode: operation code, left/right source operands and destination register.
- Produces a registered writeback record for the memory/writeback path.
- Owns the HI/LO registers and an iterative 32-cycle multiplier. While the multiplier is busy, the stage stalls decode through a ready handshake.

---
 rtl/ex_stage.sv | 187 ++++++++++++++++++
 tb/tb_ex_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: ALU, shifts, HI/LO moves and a 32-cycle shift-add multiplier.
// Latency: one cycle from accept to writeback record; MULT/MULTU results land in HI/LO at T+33.
// Backpressure: o_ready drops for the whole multiply (MUL and DONE); nothing is accepted then.
module ex_stage #(
  parameter int WORD_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MUL_CYCLES = 32   // one iteration per multiplier bit, so it tracks WORD_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [7:0]            i_exop,
  input  logic [WORD_W-1:0]     i_srcLeft,
  input  logic [WORD_W-1:0]     i_srcRight,
  input  logic [REG_ADDR_W-1:0] i_dest,
  output logic                  o_valid,
  output logic                  o_writeEnable,
  output logic [REG_ADDR_W-1:0] o_dest,
  output logic [WORD_W-1:0]     o_result,
  output logic                  o_overflow,
  output logic [WORD_W-1:0]     o_hi,
  output logic [WORD_W-1:0]     o_lo
);

  localparam int SH_W  = $clog2(WORD_W);
  localparam int CNT_W = $clog2(MUL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [3:0] CLS_LOGIC = 4'd1;
  localparam logic [3:0] CLS_ARITH = 4'd2;
  localparam int MSB = WORD_W - 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t state_q, state_d;

  logic [WORD_W-1:0] hi_q, lo_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] mcand_q;    // multiplicand magnitude
  logic [WORD_W-1:0] acc_hi_q;   // upper half of the running product
  logic [WORD_W-1:0] mplier_q;   // multiplier bits, shifted out as product low bits shift in
  logic              neg_q;

  logic              accept;
  logic [WORD_W-1:0] sum, diff, res, mag_left, mag_right;
  logic              add_ovf, sub_ovf, ovf, writes_gpr, is_mul, mul_signed, hi_wr, lo_wr, mul_neg;
  logic [SH_W-1:0]   sh;
  logic [WORD_W:0]   step_sum;
  logic [2*WORD_W-1:0] prod, prod_fin;

  assign o_ready = (state_q == S_IDLE);
  assign accept  = i_valid && o_ready;
  assign o_hi    = hi_q;
  assign o_lo    = lo_q;

  assign sh      = i_srcLeft[SH_W-1:0];
  assign sum     = i_srcLeft + i_srcRight;
  assign diff    = i_srcLeft - i_srcRight;
  assign add_ovf = (i_srcLeft[MSB] == i_srcRight[MSB]) && (sum[MSB] != i_srcLeft[MSB]);
  assign sub_ovf = (i_srcLeft[MSB] != i_srcRight[MSB]) && (diff[MSB] != i_srcLeft[MSB]);

  // MULT works on magnitudes; the sign is reapplied to the full 64-bit product in DONE.
  assign mag_left  = (mul_signed && i_srcLeft[MSB])  ? -i_srcLeft  : i_srcLeft;
  assign mag_right = (mul_signed && i_srcRight[MSB]) ? -i_srcRight : i_srcRight;
  assign mul_neg   = mul_signed && (i_srcLeft[MSB] ^ i_srcRight[MSB]);

  assign step_sum = {1'b0, acc_hi_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
  assign prod     = {acc_hi_q, mplier_q};
  assign prod_fin = neg_q ? -prod : prod;

  // Decode the operation and compute its writeback value and side effects.
  always_comb begin
    res        = '0;
    ovf        = 1'b0;
    writes_gpr = 1'b0;
    is_mul     = 1'b0;
    mul_signed = 1'b0;
    hi_wr      = 1'b0;
    lo_wr      = 1'b0;
    case (i_exop[7:4])
      CLS_LOGIC: begin
        case (i_exop[3:0])
          4'd0:    begin res = i_srcLeft & i_srcRight;    writes_gpr = 1'b1; end
          4'd1:    begin res = i_srcLeft | i_srcRight;    writes_gpr = 1'b1; end
          4'd2:    begin res = i_srcLeft ^ i_srcRight;    writes_gpr = 1'b1; end
          4'd3:    begin res = ~(i_srcLeft | i_srcRight); writes_gpr = 1'b1; end
          4'd4:    begin res = i_srcRight << sh;          writes_gpr = 1'b1; end
          4'd5:    begin res = i_srcRight >> sh;          writes_gpr = 1'b1; end
          4'd6:    begin res = $signed(i_srcRight) >>> sh; writes_gpr = 1'b1; end
          4'd7:    begin res = hi_q;                      writes_gpr = 1'b1; end
          4'd8:    begin res = lo_q;                      writes_gpr = 1'b1; end
          4'd9:    hi_wr = 1'b1;   // MTHI takes the left (rs) operand
          4'd10:   lo_wr = 1'b1;
          default: ;
        endcase
      end
      CLS_ARITH: begin
        case (i_exop[3:0])
          4'd0:    begin res = sum;  ovf = add_ovf; writes_gpr = 1'b1; end
          4'd1:    begin res = sum;                 writes_gpr = 1'b1; end
          4'd2:    begin res = diff; ovf = sub_ovf; writes_gpr = 1'b1; end
          4'd3:    begin res = diff;                writes_gpr = 1'b1; end
          4'd4:    begin
            res = {{(WORD_W-1){1'b0}}, ($signed(i_srcLeft) < $signed(i_srcRight))};
            writes_gpr = 1'b1;
          end
          4'd5:    begin res = {{(WORD_W-1){1'b0}}, (i_srcLeft < i_srcRight)}; writes_gpr = 1'b1; end
          4'd6:    begin is_mul = 1'b1; mul_signed = 1'b1; end
          4'd7:    is_mul = 1'b1;
          default: ;
        endcase
      end
      default: ;   // special class and unknown classes behave as NOP
    endcase
  end

  // Multiplier sequencing: IDLE -> MUL (MUL_CYCLES iterations) -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_mul) state_d = S_MUL;
      S_MUL:   if (cnt_q == CNT_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset also aborts any multiply in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Shift-add datapath: latch magnitudes on accept, then add/shift one bit per MUL cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
    end else if (state_q == S_IDLE) begin
      if (accept && is_mul) begin
        cnt_q    <= '0;
        mcand_q  <= mag_left;
        acc_hi_q <= '0;
        mplier_q <= mag_right;
        neg_q    <= mul_neg;
      end
    end else if (state_q == S_MUL) begin
      acc_hi_q <= step_sum[WORD_W:1];
      mplier_q <= {step_sum[0], mplier_q[WORD_W-1:1]};
      cnt_q    <= cnt_q + 1'b1;
    end
  end

  // HI/LO: product written in DONE; MTHI/MTLO written on their accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state_q == S_DONE) begin
      {hi_q, lo_q} <= prod_fin;
    end else if (accept) begin
      if (hi_wr) hi_q <= i_srcLeft;
      if (lo_wr) lo_q <= i_srcLeft;
    end
  end

  // Writeback record: a one-cycle pulse per accepted operation, zeros otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid       <= 1'b0;
      o_writeEnable <= 1'b0;
      o_overflow    <= 1'b0;
      o_dest        <= '0;
      o_result      <= '0;
    end else begin
      o_valid       <= accept;
      o_writeEnable <= accept && writes_gpr && (i_dest != '0) && !ovf;
      o_overflow    <= accept && ovf;
      o_dest        <= accept ? i_dest : '0;
      o_result      <= accept ? res : '0;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed cases plus randomized ops against a behavioural model.
// Latency: checks writeback one cycle after accept and HI/LO after the multiply stall.
// Backpressure: holds an op valid through the multiply stall and checks it is taken afterwards.
module tb_ex_stage;

  logic        clk, rst, i_valid, o_ready;
  logic [7:0]  i_exop;
  logic [31:0] i_srcLeft, i_srcRight;
  logic [4:0]  i_dest;
  logic        o_valid, o_writeEnable, o_overflow;
  logic [4:0]  o_dest;
  logic [31:0] o_result, o_hi, o_lo;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_hi, m_lo;

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] l;
    logic [31:0] r;
    logic [4:0]  d;
    logic [31:0] res;
    logic        we;
    logic        ovf;
  } vec_t;

  ex_stage #(.WORD_W(32), .REG_ADDR_W(5), .MUL_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_exop(i_exop), .i_srcLeft(i_srcLeft), .i_srcRight(i_srcRight), .i_dest(i_dest),
    .o_valid(o_valid), .o_writeEnable(o_writeEnable), .o_dest(o_dest),
    .o_result(o_result), .o_overflow(o_overflow), .o_hi(o_hi), .o_lo(o_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present an op and advance past the next rising edge; valid stays high for back-to-back use.
  task automatic drive_op(input logic [7:0] op, input logic [31:0] l, input logic [31:0] r,
                          input logic [4:0] d);
    i_valid = 1'b1; i_exop = op; i_srcLeft = l; i_srcRight = r; i_dest = d;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Reference behaviour from the instruction definitions, using wide integer arithmetic.
  task automatic model_op(input logic [7:0] op, input logic [31:0] l, input logic [31:0] r,
                          input logic [4:0] d, output logic [31:0] e_res, output logic e_we,
                          output logic e_ovf);
    longint sl, sr, s;
    logic [63:0] up;
    logic wr;
    int sh;
    sl = longint'($signed(l)); sr = longint'($signed(r)); sh = int'(l[4:0]);
    e_res = 32'h0; e_ovf = 1'b0; wr = 1'b0;
    if (op[7:4] == 4'd1) begin
      wr = 1'b1;
      case (op[3:0])
        4'd0: e_res = l & r;
        4'd1: e_res = l | r;
        4'd2: e_res = l ^ r;
        4'd3: e_res = ~(l | r);
        4'd4: e_res = r << sh;
        4'd5: e_res = r >> sh;
        4'd6: e_res = (r >> sh) | (r[31] ? ~(32'hFFFFFFFF >> sh) : 32'h0);
        4'd7: e_res = m_hi;
        4'd8: e_res = m_lo;
        4'd9: begin m_hi = l; wr = 1'b0; end
        4'd10: begin m_lo = l; wr = 1'b0; end
        default: wr = 1'b0;
      endcase
    end else if (op[7:4] == 4'd2) begin
      wr = 1'b1;
      case (op[3:0])
        4'd0: begin s = sl + sr; e_res = s[31:0]; e_ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
        4'd1: e_res = l + r;
        4'd2: begin s = sl - sr; e_res = s[31:0]; e_ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
        4'd3: e_res = l - r;
        4'd4: e_res = (sl < sr) ? 32'd1 : 32'd0;
        4'd5: e_res = (longint'(l) < longint'(r)) ? 32'd1 : 32'd0;
        4'd6: begin s = sl * sr; {m_hi, m_lo} = s; wr = 1'b0; end
        4'd7: begin up = 64'(l) * 64'(r); {m_hi, m_lo} = up; wr = 1'b0; end
        default: wr = 1'b0;
      endcase
    end
    e_we = wr && (d != 5'd0) && !e_ovf;
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h7FFFFFFF;
      2: return 32'h80000000;
      3: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; i_exop = 8'h0; i_srcLeft = 32'h0; i_srcRight = 32'h0; i_dest = 5'h0;
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_writeEnable !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", o_writeEnable); end
    n_cmp++; if (o_overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", o_overflow); end
    n_cmp++; if (o_result !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h want 0", o_result); end
    n_cmp++; if (o_dest !== 5'h0) begin n_bad++; $display("FAIL reset_dest: got %h want 0", o_dest); end
    n_cmp++; if (o_hi !== 32'h0 || o_lo !== 32'h0) begin n_bad++; $display("FAIL reset_hilo: got %h/%h want 0/0", o_hi, o_lo); end
    rst = 1'b0; m_hi = 32'h0; m_lo = 32'h0;
  endtask

  task automatic test_alu_directed();
    vec_t v[14];
    v[0]  = '{8'h20, 32'h7FFFFFFF, 32'h00000001, 5'd3, 32'h80000000, 1'b0, 1'b1};
    v[1]  = '{8'h21, 32'h7FFFFFFF, 32'h00000001, 5'd3, 32'h80000000, 1'b1, 1'b0};
    v[2]  = '{8'h16, 32'd4,        32'h80000000, 5'd5, 32'hF8000000, 1'b1, 1'b0};
    v[3]  = '{8'h15, 32'd4,        32'h80000000, 5'd5, 32'h08000000, 1'b1, 1'b0};
    v[4]  = '{8'h14, 32'd31,       32'h00000001, 5'd5, 32'h80000000, 1'b1, 1'b0};
    v[5]  = '{8'h24, 32'hFFFFFFFF, 32'h00000001, 5'd6, 32'h00000001, 1'b1, 1'b0};
    v[6]  = '{8'h25, 32'hFFFFFFFF, 32'h00000001, 5'd6, 32'h00000000, 1'b1, 1'b0};
    v[7]  = '{8'h24, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000001, 1'b0, 1'b0};
    v[8]  = '{8'h00, 32'h00000011, 32'h00000022, 5'd4, 32'h00000000, 1'b0, 1'b0};
    v[9]  = '{8'h22, 32'h80000000, 32'h00000001, 5'd2, 32'h7FFFFFFF, 1'b0, 1'b1};
    v[10] = '{8'h23, 32'h80000000, 32'h00000001, 5'd2, 32'h7FFFFFFF, 1'b1, 1'b0};
    v[11] = '{8'h13, 32'hF0F0F0F0, 32'h0F0F00FF, 5'd9, 32'h00000F00, 1'b1, 1'b0};
    v[12] = '{8'h3C, 32'h00000001, 32'h00000002, 5'd9, 32'h00000000, 1'b0, 1'b0};
    v[13] = '{8'h1F, 32'h00000001, 32'h00000002, 5'd9, 32'h00000000, 1'b0, 1'b0};
    for (int i = 0; i < 14; i++) begin
      drive_op(v[i].op, v[i].l, v[i].r, v[i].d);
      n_cmp++; if (o_valid !== 1'b1 || o_dest !== v[i].d) begin n_bad++; $display("FAIL dir%0d_valid_dest: got %b/%0d want 1/%0d", i, o_valid, o_dest, v[i].d); end
      n_cmp++; if (o_result !== v[i].res) begin n_bad++; $display("FAIL dir%0d_result: got %h want %h", i, o_result, v[i].res); end
      n_cmp++; if (o_writeEnable !== v[i].we || o_overflow !== v[i].ovf) begin n_bad++; $display("FAIL dir%0d_we_ovf: got %b/%b want %b/%b", i, o_writeEnable, o_overflow, v[i].we, v[i].ovf); end
    end
    idle(1);
    n_cmp++; if (o_valid !== 1'b0 || o_writeEnable !== 1'b0 || o_overflow !== 1'b0) begin n_bad++; $display("FAIL idle_pulse: got %b%b%b want 000", o_valid, o_writeEnable, o_overflow); end
  endtask

  task automatic test_back_to_back_hilo();
    drive_op(8'h19, 32'h12345678, 32'hDEADBEEF, 5'd9);
    n_cmp++; if (o_valid !== 1'b1 || o_writeEnable !== 1'b0 || o_result !== 32'h0) begin n_bad++; $display("FAIL mthi_record: got %b/%b/%h want 1/0/0", o_valid, o_writeEnable, o_result); end
    drive_op(8'h17, 32'h0, 32'h0, 5'd7);
    n_cmp++; if (o_result !== 32'h12345678 || o_writeEnable !== 1'b1 || o_dest !== 5'd7) begin n_bad++; $display("FAIL mfhi_b2b: got %h/%b/%0d want 12345678/1/7", o_result, o_writeEnable, o_dest); end
    drive_op(8'h1A, 32'hCAFEF00D, 32'h0, 5'd0);
    drive_op(8'h18, 32'h0, 32'h0, 5'd8);
    n_cmp++; if (o_result !== 32'hCAFEF00D || o_writeEnable !== 1'b1) begin n_bad++; $display("FAIL mflo_b2b: got %h/%b want cafef00d/1", o_result, o_writeEnable); end
    n_cmp++; if (o_hi !== 32'h12345678 || o_lo !== 32'hCAFEF00D) begin n_bad++; $display("FAIL hilo_ports: got %h/%h want 12345678/cafef00d", o_hi, o_lo); end
    idle(1);
    m_hi = 32'h12345678; m_lo = 32'hCAFEF00D;
  endtask

  // One multiply with a follow-on ADDU held valid through the stall.
  task automatic run_mult(input logic [7:0] op, input logic [31:0] l, input logic [31:0] r,
                          input string tag);
    logic [31:0] old_hi, old_lo, e_res;
    logic e_we, e_ovf;
    int n;
    old_hi = m_hi; old_lo = m_lo;
    model_op(op, l, r, 5'd6, e_res, e_we, e_ovf);
    drive_op(op, l, r, 5'd6);
    n_cmp++; if (o_valid !== 1'b1 || o_writeEnable !== 1'b0 || o_result !== 32'h0) begin n_bad++; $display("FAIL %s_record: got %b/%b/%h want 1/0/0", tag, o_valid, o_writeEnable, o_result); end
    i_exop = 8'h21; i_srcLeft = 32'h10; i_srcRight = 32'h20; i_dest = 5'd4;
    n = 0;
    while (o_ready !== 1'b1 && n < 100) begin
      n++;
      @(posedge clk); #1;
      n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL %s_stall_accept: got valid %b want 0 at stall %0d", tag, o_valid, n); end
      if (o_ready !== 1'b1) begin
        n_cmp++; if (o_hi !== old_hi || o_lo !== old_lo) begin n_bad++; $display("FAIL %s_hilo_early: got %h/%h want %h/%h", tag, o_hi, o_lo, old_hi, old_lo); end
      end
    end
    n_cmp++; if (n !== 33) begin n_bad++; $display("FAIL %s_stall_len: got %0d want 33", tag, n); end
    n_cmp++; if (o_hi !== m_hi || o_lo !== m_lo) begin n_bad++; $display("FAIL %s_product: got %h/%h want %h/%h", tag, o_hi, o_lo, m_hi, m_lo); end
    @(posedge clk); #1;
    n_cmp++; if (o_valid !== 1'b1 || o_result !== 32'h30 || o_dest !== 5'd4) begin n_bad++; $display("FAIL %s_held_op: got %b/%h/%0d want 1/30/4", tag, o_valid, o_result, o_dest); end
    idle(1);
  endtask

  task automatic test_mult_directed();
    run_mult(8'h26, 32'hFFFFFFFD, 32'd5, "mult_m3x5");
    n_cmp++; if (o_hi !== 32'hFFFFFFFF || o_lo !== 32'hFFFFFFF1) begin n_bad++; $display("FAIL mult_m3x5_const: got %h/%h want ffffffff/fffffff1", o_hi, o_lo); end
    run_mult(8'h27, 32'hFFFFFFFF, 32'd2, "multu_max");
    n_cmp++; if (o_hi !== 32'h00000001 || o_lo !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL multu_max_const: got %h/%h want 00000001/fffffffe", o_hi, o_lo); end
    run_mult(8'h26, 32'h80000000, 32'h80000000, "mult_minint");
    n_cmp++; if (o_hi !== 32'h40000000 || o_lo !== 32'h0) begin n_bad++; $display("FAIL mult_minint_const: got %h/%h want 40000000/0", o_hi, o_lo); end
  endtask

  task automatic test_reset_mid_mult();
    drive_op(8'h19, 32'hA5A5A5A5, 32'h0, 5'd0);
    drive_op(8'h26, 32'd7, 32'd9, 5'd1);
    i_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_hi = 32'h0; m_lo = 32'h0;
    n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready: got %b want 1", o_ready); end
    n_cmp++; if (o_hi !== 32'h0 || o_lo !== 32'h0) begin n_bad++; $display("FAIL rst_mid_hilo: got %h/%h want 0/0", o_hi, o_lo); end
    @(posedge clk); #1;
    n_cmp++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_after: got ready %b valid %b want 1/0", o_ready, o_valid); end
    idle(40);
    n_cmp++; if (o_hi !== 32'h0 || o_lo !== 32'h0) begin n_bad++; $display("FAIL rst_mid_late: got %h/%h want 0/0", o_hi, o_lo); end
  endtask

  task automatic test_random_alu();
    logic [7:0] op;
    logic [31:0] l, r, e_res;
    logic [4:0] d;
    logic e_we, e_ovf;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_gap: got valid %b want 0", i, o_valid); end
      end
      op = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
      if (op[7:4] == 4'd2 && (op[3:0] == 4'd6 || op[3:0] == 4'd7)) op[3:0] = 4'd0;
      l = rand_word(); r = rand_word(); d = 5'($urandom_range(0, 31));
      model_op(op, l, r, d, e_res, e_we, e_ovf);
      drive_op(op, l, r, d);
      n_cmp++; if (o_valid !== 1'b1 || o_dest !== d) begin n_bad++; $display("FAIL rnd%0d_valid_dest op %h: got %b/%0d want 1/%0d", i, op, o_valid, o_dest, d); end
      n_cmp++; if (o_result !== e_res) begin n_bad++; $display("FAIL rnd%0d_result op %h l %h r %h: got %h want %h", i, op, l, r, o_result, e_res); end
      n_cmp++; if (o_writeEnable !== e_we || o_overflow !== e_ovf) begin n_bad++; $display("FAIL rnd%0d_we_ovf op %h: got %b/%b want %b/%b", i, op, o_writeEnable, o_overflow, e_we, e_ovf); end
      n_cmp++; if (o_hi !== m_hi || o_lo !== m_lo) begin n_bad++; $display("FAIL rnd%0d_hilo: got %h/%h want %h/%h", i, o_hi, o_lo, m_hi, m_lo); end
    end
    idle(1);
  endtask

  task automatic test_random_mult();
    for (int i = 0; i < 8; i++) begin
      run_mult($urandom_range(0, 1) ? 8'h26 : 8'h27, rand_word(), rand_word(), "rnd_mul");
    end
  endtask

  initial begin
    test_reset();
    test_alu_directed();
    test_back_to_back_hilo();
    test_mult_directed();
    test_reset_mid_mult();
    test_random_alu();
    test_random_mult();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
